mole_scheduler: RTL and testbench

//   Game sequencer for whack-a-mole. Consumes the 5-bit free-running rand value
//   (cycles 1..30; 0 only during reset) and turns it into timed mole appearances.

---
 rtl/mole_scheduler.sv | 126 ++++++++++++
 tb/tb_mole_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole round sequencer: turns the rand_gen value into timed one-hot mole
// appearances, times each mole and keeps saturating hit/miss counts for a round.
module mole_scheduler #(
  parameter int NUM_HOLES   = 9,
  parameter int UP_TICKS    = 800,
  parameter int GAP_TICKS   = 300,
  parameter int ROUND_MOLES = 20,
  parameter int SCORE_W     = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               tick,
  input  logic [4:0]                         rand_val,
  input  logic [NUM_HOLES-1:0]               hit,
  output logic [NUM_HOLES-1:0]               mole,
  output logic [SCORE_W-1:0]                 score,
  output logic [SCORE_W-1:0]                 misses,
  output logic [$clog2(ROUND_MOLES+1)-1:0]   moles_left,
  output logic                               busy,
  output logic                               done
);

  localparam int TIMER_MAX = (UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS;
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam int LW        = $clog2(ROUND_MOLES + 1);

  typedef enum logic [1:0] {IDLE, GAP, UP, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [4:0]    last_hole;
  logic          last_valid;
  logic [4:0]    h_raw;
  logic [4:0]    h_pick;
  logic          mole_hit;
  logic          timed_out;

  // Pick the next hole; a repeat of the previous hole is bumped to its neighbour.
  always_comb begin
    h_raw  = rand_val % 5'(NUM_HOLES);
    h_pick = h_raw;
    if (last_valid && (h_raw == last_hole))
      h_pick = (h_raw == 5'(NUM_HOLES - 1)) ? 5'd0 : h_raw + 5'd1;
  end

  // mole is one-hot on the raised hole, so masking hit with it isolates hit[h].
  assign mole_hit  = |(hit & mole);
  assign timed_out = tick && (timer == TW'(1));

  // NOTE: reset is sampled on the clock edge (synchronous) and every state
  // register uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      mole       <= '0;
      score      <= '0;
      misses     <= '0;
      moles_left <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timer      <= '0;
      last_hole  <= '0;
      last_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            score      <= '0;
            misses     <= '0;
            moles_left <= LW'(ROUND_MOLES);
            timer      <= TW'(GAP_TICKS);
            last_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= GAP;
          end
        end

        GAP: begin
          if (tick) begin
            if (timer == TW'(1)) begin
              mole       <= NUM_HOLES'(1) << h_pick;
              last_hole  <= h_pick;
              last_valid <= 1'b1;
              timer      <= TW'(UP_TICKS);
              state      <= UP;
            end else begin
              timer <= timer - TW'(1);
            end
          end
        end

        UP: begin
          if (mole_hit || timed_out) begin
            // A hit wins over a simultaneous timeout.
            if (mole_hit) begin
              if (score != '1) score <= score + SCORE_W'(1);
            end else if (misses != '1) begin
              misses <= misses + SCORE_W'(1);
            end
            mole       <= '0;
            moles_left <= moles_left - LW'(1);
            if (moles_left == LW'(1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              timer <= TW'(GAP_TICKS);
              state <= GAP;
            end
          end else if (tick) begin
            timer <= timer - TW'(1);
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Scoreboard bench for mole_scheduler: a round-level model predicts every mole
// appearance, removal and round boundary with the edge on which it must occur.
module tb_mole_scheduler;

  localparam int NH     = 9;
  localparam int UT     = 4;
  localparam int GT     = 2;
  localparam int RM     = 3;
  localparam int SW     = 8;
  localparam int LW     = $clog2(RM + 1);
  localparam int SMAX   = (1 << SW) - 1;
  localparam int SAT_RM = 5;
  localparam int SAT_SW = 2;
  localparam int SAT_LW = $clog2(SAT_RM + 1);

  typedef enum int {EV_BUSY_RISE, EV_APPEAR, EV_CLEAR, EV_DONE, EV_BUSY_FALL} ev_kind_t;
  typedef struct {
    ev_kind_t        kind;
    int              edge_no;
    logic [NH-1:0]   mole;
    int              score;
    int              misses;
    int              left;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              tick = 1'b1;
  logic [4:0]        rand_v = 5'd1;
  logic [NH-1:0]     hit = '0;
  logic [NH-1:0]     mole;
  logic [SW-1:0]     score, misses;
  logic [LW-1:0]     moles_left;
  logic              busy, done;

  logic              sat_start = 1'b0;
  logic [NH-1:0]     sat_hit = '0;
  logic [NH-1:0]     sat_mole;
  logic [SAT_SW-1:0] sat_score, sat_misses;
  logic [SAT_LW-1:0] sat_left;
  logic              sat_busy, sat_done;

  int   n_checks = 0;
  int   n_errors = 0;
  int   edge_n = 0;
  bit   mon_en = 1'b0;
  logic prev_busy;
  logic [NH-1:0] prev_mole;
  ev_t  sb[$];

  int   m_score, m_misses, m_left, m_last_hole;
  bit   m_last_valid;

  mole_scheduler #(.NUM_HOLES(NH), .UP_TICKS(UT), .GAP_TICKS(GT),
                   .ROUND_MOLES(RM), .SCORE_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .rand_val(rand_v),
    .hit(hit), .mole(mole), .score(score), .misses(misses),
    .moles_left(moles_left), .busy(busy), .done(done)
  );

  mole_scheduler #(.NUM_HOLES(NH), .UP_TICKS(UT), .GAP_TICKS(GT),
                   .ROUND_MOLES(SAT_RM), .SCORE_W(SAT_SW)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(sat_start), .tick(tick), .rand_val(rand_v),
    .hit(sat_hit), .mole(sat_mole), .score(sat_score), .misses(sat_misses),
    .moles_left(sat_left), .busy(sat_busy), .done(sat_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic push(input ev_kind_t k, input logic [NH-1:0] m);
    ev_t e;
    e.kind = k; e.edge_no = edge_n; e.mole = m;
    e.score = m_score; e.misses = m_misses; e.left = m_left;
    sb.push_back(e);
  endtask

  task automatic expect_ev(input ev_kind_t k);
    ev_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_unexpected: got event kind %0d at edge %0d, expected none", k, edge_n);
    end else begin
      e = sb.pop_front();
      check("ev_kind", k, e.kind);
      check("ev_edge", edge_n, e.edge_no);
      case (e.kind)
        EV_APPEAR: check("mole", mole, e.mole);
        EV_CLEAR: begin
          check("clear_score", score, e.score);
          check("clear_misses", misses, e.misses);
          check("clear_moles_left", moles_left, e.left);
        end
        EV_DONE: begin
          check("done_score", score, e.score);
          check("done_misses", misses, e.misses);
        end
        default: ;
      endcase
    end
  endtask

  // Monitor: any visible output transition must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy && !prev_busy) expect_ev(EV_BUSY_RISE);
      if (mole != prev_mole) expect_ev((mole != '0) ? EV_APPEAR : EV_CLEAR);
      if (done) expect_ev(EV_DONE);
      if (!busy && prev_busy) expect_ev(EV_BUSY_FALL);
      check("mole_onehot", $countones(mole) <= 1, 1);
      if (busy) check("sum_invariant", int'(score) + int'(misses) + int'(moles_left), RM);
    end
    prev_busy = busy;
    prev_mole = mole;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input bit rnd);
    start  = 1'b1;
    rand_v = 5'($urandom_range(30, 1));
    hit    = rnd ? NH'($urandom) : '0;
    cycle();
    start = 1'b0;
    hit   = '0;
    m_score = 0; m_misses = 0; m_left = RM; m_last_valid = 1'b0;
    push(EV_BUSY_RISE, '0);
  endtask

  // One mole: gap, appearance, then a hit on up-cycle hit_at (0 = let it time out).
  // abort_at>0 pulls rst_n low during that up-cycle instead.
  task automatic play_mole(input int r, input int hit_at, input logic [NH-1:0] noise,
                           input bit rnd, input int abort_at);
    int h;
    logic [NH-1:0] oh;
    h = r % NH;
    if (m_last_valid && h == m_last_hole) h = (h + 1) % NH;
    oh = '0;
    oh[h] = 1'b1;
    for (int g = 1; g <= GT; g++) begin
      rand_v = (g == GT) ? 5'(r) : 5'($urandom_range(30, 1));
      hit    = rnd ? (NH'($urandom) & noise) : noise;
      start  = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
      cycle();
    end
    m_last_hole = h;
    m_last_valid = 1'b1;
    push(EV_APPEAR, oh);
    for (int k = 1; k <= UT; k++) begin
      rand_v = 5'($urandom_range(30, 1));
      start  = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
      hit    = (rnd ? (NH'($urandom) & noise) : noise) & ~oh;
      if (k == hit_at) hit = hit | oh;
      if (k == abort_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        cycle();
        rst_n = 1'b1;
        hit = '0;
        m_score = 0; m_misses = 0; m_left = 0; m_last_valid = 1'b0;
        push(EV_CLEAR, '0);
        push(EV_BUSY_FALL, '0);
        return;
      end
      cycle();
      if (k == hit_at) begin
        m_score = (m_score == SMAX) ? SMAX : m_score + 1;
        break;
      end else if (k == UT) begin
        m_misses = (m_misses == SMAX) ? SMAX : m_misses + 1;
      end
    end
    m_left--;
    push(EV_CLEAR, '0);
    start = 1'b0;
    if (m_left == 0) begin
      push(EV_DONE, '0);
      start = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
      hit   = rnd ? NH'($urandom) : '0;
      cycle();
      push(EV_BUSY_FALL, '0);
    end
    start = 1'b0;
    hit   = '0;
  endtask

  initial begin
    bit seen;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); rand_v = 5'($urandom); hit = NH'($urandom);
      sat_start = 1'($urandom); sat_hit = NH'($urandom);
      cycle();
    end
    @(negedge clk);
    check("rst_mole", mole, 0);
    check("rst_score", score, 0);
    check("rst_misses", misses, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_moles_left", moles_left, 0);
    rst_n = 1'b1; start = 1'b0; hit = '0; sat_start = 1'b0; sat_hit = '0; rand_v = 5'd1;
    cycle();
    mon_en = 1'b1;

    // Saturation: 5 hits into a 2-bit score must stop at 3.
    sat_start = 1'b1;
    cycle();
    sat_start = 1'b0;
    sat_hit = '1;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sat_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("sat_done_seen", seen, 1);
    check("sat_score", sat_score, (1 << SAT_SW) - 1);
    check("sat_misses", sat_misses, 0);
    check("sat_moles_left", sat_left, 0);
    sat_hit = '0;
    cycle();

    // Directed round: hit, repeated-hole timeout with stray hit[2], final-tick hit.
    start_round(1'b0);
    play_mole(5, 1, '0, 1'b0, 0);
    play_mole(14, 0, 9'h004, 1'b0, 0);
    play_mole(30, UT, '0, 1'b0, 0);
    @(negedge clk);
    check("round_score", score, 2);
    check("round_misses", misses, 1);
    check("round_busy", busy, 0);
    check("round_done", done, 0);

    repeat (8) begin
      repeat ($urandom_range(3, 0)) cycle();
      start_round(1'b1);
      for (int m = 0; m < RM; m++)
        play_mole($urandom_range(30, 1), $urandom_range(UT, 0), NH'($urandom), 1'b1, 0);
    end

    // Mid-round reset during the second mole's up-time.
    start_round(1'b1);
    play_mole($urandom_range(30, 1), $urandom_range(UT, 0), NH'($urandom), 1'b1, 0);
    play_mole($urandom_range(30, 1), 0, '0, 1'b1, 2);
    cycle();
    start_round(1'b1);
    for (int m = 0; m < RM; m++)
      play_mole($urandom_range(30, 1), $urandom_range(UT, 0), NH'($urandom), 1'b1, 0);

    repeat (4) cycle();
    check("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
